// File: rtl/tx_eight_ten.sv
// tx_eight_ten: UART transmit framer. Accepts bytes on a valid/ready
// handshake and sends each one as a 10-bit frame on tx_out: a start bit (0),
// eight data bits LSB first, then a stop bit (1). Each bit lasts baud_l
// clk cycles. One byte can wait in a holding buffer while a frame is on the
// line, so consecutive frames can go out with no idle gap between them.
//
// Ports:
//   clk          system clock; every state update is on the rising edge
//   rst          synchronous reset, active low
//   baud         bit period in clk cycles (0 is treated as 1), latched at
//                each frame start
//   tx_en        transmitter enable
//   tx_valid     upstream is offering tx_data
//   tx_data      byte to send
//   tx_ready     a byte is accepted this cycle (combinational)
//   tx_out       serial line, registered; high when idle
//   tx_busy      a frame is in progress, registered
//   bit_cnt_out  current frame bit: 0 start, 1-8 data, 9 stop; 0 when idle
module tx_eight_ten #(
    parameter int unsigned BAUD_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BAUD_W-1:0] baud,
    input  logic              tx_en,
    input  logic              tx_valid,
    input  logic [7:0]        tx_data,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic [3:0]        bit_cnt_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [7:0]        shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [BAUD_W-1:0] per_q, per_d;
    logic [BAUD_W-1:0] baud_l_q, baud_l_d;
    logic              tx_out_q, tx_out_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              per_wrap;
    logic              start_frame;
    logic [BAUD_W-1:0] baud_eff;

    // Accept only with a free holding slot; forced low while reset is asserted.
    assign tx_ready = rst & tx_en & ~hold_full_q;
    assign accept   = tx_valid & tx_ready;
    assign baud_eff = (baud == '0) ? BAUD_W'(1) : baud;
    assign per_wrap = (per_q == (baud_l_q - BAUD_W'(1)));

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        per_d       = per_q;
        baud_l_d    = baud_l_q;
        tx_out_d    = tx_out_q;
        busy_d      = busy_q;
        start_frame = 1'b0;

        // A byte accepted while a frame is running goes into the holding slot.
        if ((state_q != IDLE) && accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (state_q == IDLE) begin
            // accept implies an empty holding slot, so the two are exclusive.
            if (accept) begin
                shift_d     = tx_data;
                start_frame = 1'b1;
            end else if (hold_full_q && tx_en) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
                start_frame = 1'b1;
            end
        end else begin
            per_d = per_wrap ? '0 : (per_q + BAUD_W'(1));
            if (per_wrap) begin
                if (state_q == START) begin
                    state_d   = DATA;
                    tx_out_d  = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = 4'd1;
                end else if (state_q == DATA) begin
                    if (bit_cnt_q == 4'd8) begin
                        state_d   = STOP;
                        tx_out_d  = 1'b1;
                        bit_cnt_d = 4'd9;
                    end else begin
                        tx_out_d  = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = 4'(bit_cnt_q + 4'd1);
                    end
                end else begin
                    // End of stop bit: chain straight into a held byte if allowed.
                    if (hold_full_q && tx_en) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        start_frame = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        tx_out_d  = 1'b1;
                        busy_d    = 1'b0;
                        bit_cnt_d = 4'd0;
                    end
                end
            end
        end

        // Frame start: latch the bit period and drive the start bit next cycle.
        if (start_frame) begin
            state_d   = START;
            baud_l_d  = baud_eff;
            per_d     = '0;
            tx_out_d  = 1'b0;
            busy_d    = 1'b1;
            bit_cnt_d = 4'd0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            shift_q     <= 8'd0;
            bit_cnt_q   <= 4'd0;
            per_q       <= '0;
            baud_l_q    <= '0;
            tx_out_q    <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            per_q       <= per_d;
            baud_l_q    <= baud_l_d;
            tx_out_q    <= tx_out_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_out      = tx_out_q;
    assign tx_busy     = busy_q;
    assign bit_cnt_out = bit_cnt_q;

endmodule

// File: tb/tb_tx_eight_ten.sv
// Testbench for tx_eight_ten. Every accepted byte is pushed to a scoreboard
// along with the bit period it should use. A line monitor pops one entry per
// frame, checks the line, busy and bit index on every cycle of the frame, and
// also recovers the byte by sampling the middle of each bit, the way a
// receiver on the same baud would.
module tb_tx_eight_ten;

    logic        clk;
    logic        rst;
    logic [19:0] baud;
    logic        tx_en;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        tx_out;
    logic        tx_busy;
    logic [3:0]  bit_cnt_out;

    tx_eight_ten #(.BAUD_W(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .baud        (baud),
        .tx_en       (tx_en),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_out      (tx_out),
        .tx_busy     (tx_busy),
        .bit_cnt_out (bit_cnt_out)
    );

    typedef struct {
        logic [7:0] data;
        int         b;
    } item_t;

    item_t exp_q[$];
    int    starts_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    logic  rst_at_edge = 1'b0;
    logic  in_frame = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Line monitor, sampling on the falling edge.
    initial begin : monitor
        item_t      cur;
        int         c;
        int         bidx;
        logic       expbit;
        logic [7:0] rxb;
        c   = 0;
        rxb = 8'd0;
        cur = '{8'd0, 1};
        forever begin
            @(negedge clk);
            if (!rst_at_edge) begin
                // Reset at the last edge: any frame is aborted and held bytes are dropped.
                in_frame = 1'b0;
                exp_q.delete();
                chk("reset_out", 32'({tx_out, tx_busy, bit_cnt_out}), 32'(6'b100000));
            end else begin
                if (!in_frame && (tx_out == 1'b0)) begin
                    chk("frame_expected", 32'(exp_q.size() != 0), 32'(1));
                    if (exp_q.size() != 0) begin
                        cur      = exp_q.pop_front();
                        c        = 0;
                        rxb      = 8'd0;
                        in_frame = 1'b1;
                        starts_q.push_back(cyc);
                    end
                end
                if (in_frame) begin
                    bidx   = c / cur.b;
                    expbit = (bidx == 0) ? 1'b0 : (bidx == 9) ? 1'b1 : cur.data[bidx-1];
                    chk("frame_cycle", 32'({tx_out, tx_busy, bit_cnt_out}),
                        32'({expbit, 1'b1, 4'(bidx)}));
                    if ((bidx >= 1) && (bidx <= 8) && ((c % cur.b) == (cur.b / 2)))
                        rxb[bidx-1] = tx_out;
                    c++;
                    if (c == 10 * cur.b) begin
                        in_frame = 1'b0;
                        chk("rx_byte", 32'(rxb), 32'(cur.data));
                    end
                end else begin
                    chk("idle_out", 32'({tx_out, tx_busy, bit_cnt_out}), 32'(6'b100000));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a byte and wait (bounded) for it to be taken; returns the accept cycle.
    task automatic send_byte(input logic [7:0] d, output int acc);
        int eff;
        acc      = -1;
        tx_valid = 1'b1;
        tx_data  = d;
        for (int i = 0; i < 2000 && acc < 0; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                eff = (baud == 20'd0) ? 1 : int'(baud);
                exp_q.push_back('{d, eff});
                @(posedge clk);
                #1;
                acc = cyc;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        tx_valid = 1'b0;
        chk("accepted", 32'(acc >= 0), 32'(1));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drained", 32'(exp_q.size() + int'(in_frame)), 32'(0));
        tick(2);
    endtask

    initial begin : stim
        int a0, a1, a2, e;
        int n;
        rst      = 1'b0;
        tx_en    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'd0;
        baud     = 20'd4;

        // Reset: ready held low while rst is low, then follows tx_en.
        tick(1);
        @(negedge clk);
        chk("ready_in_reset", 32'(tx_ready), 32'(0));
        tick(2);
        rst = 1'b1;
        tick(2);
        @(negedge clk);
        chk("ready_after_reset", 32'(tx_ready), 32'(1));
        tick(1);

        // Basic frame 0xA5 at baud 4, start bit one cycle after accept.
        starts_q.delete();
        send_byte(8'hA5, a0);
        wait_idle(200);
        chk("basic_nframes", 32'(starts_q.size()), 32'(1));
        chk("basic_latency", 32'(starts_q[0]), 32'(a0));

        // Buffering at baud 2: 0x3C stalls until the 0x00 frame's stop bit ends.
        baud = 20'd2;
        starts_q.delete();
        send_byte(8'h00, a0);
        send_byte(8'hFF, a1);
        send_byte(8'h3C, a2);
        wait_idle(300);
        chk("buf_nframes", 32'(starts_q.size()), 32'(3));
        chk("buf_latency", 32'(starts_q[0]), 32'(a0));
        chk("buf_hold_accept", 32'(a1 - a0), 32'(1));
        chk("buf_contig_1", 32'(starts_q[1] - starts_q[0]), 32'(20));
        chk("buf_stall", 32'(a2 - starts_q[0]), 32'(21));
        chk("buf_contig_2", 32'(starts_q[2] - starts_q[1]), 32'(20));

        // Baud 0 and 1 both give 1-cycle bits.
        baud = 20'd0;
        send_byte(8'h81, a0);
        wait_idle(100);
        baud = 20'd1;
        send_byte(8'h81, a0);
        wait_idle(100);

        // Baud change mid-frame: current frame keeps 3, held frame uses 8.
        baud = 20'd3;
        starts_q.delete();
        send_byte(8'h6B, a0);
        tick(5);
        baud = 20'd8;
        send_byte(8'h94, a1);
        wait_idle(400);
        chk("baud_chg_gap", 32'(starts_q[1] - starts_q[0]), 32'(30));

        // Enable dropped mid-frame with a byte held.
        baud = 20'd4;
        send_byte(8'h5A, a0);
        send_byte(8'hC3, a1);
        tick(10);
        tx_en = 1'b0;
        n = 0;
        while (in_frame && n < 200) begin
            @(negedge clk);
            n++;
        end
        tick(12);
        @(negedge clk);
        chk("en_ready_low", 32'(tx_ready), 32'(0));
        chk("en_held_pending", 32'(exp_q.size()), 32'(1));
        chk("en_line_idle", 32'({tx_out, tx_busy}), 32'(2'b10));
        @(posedge clk);
        #1;
        tx_en = 1'b1;
        e = cyc;
        starts_q.delete();
        wait_idle(200);
        chk("en_resume_lat", 32'(starts_q[0] - e), 32'(1));

        // Reset during data with a held byte: the held byte must never appear.
        send_byte(8'h0F, a0);
        send_byte(8'hF0, a1);
        n = 0;
        while (bit_cnt_out != 4'd3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_bit3", 32'(bit_cnt_out), 32'(3));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_low", 32'(tx_ready), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_line_high", 32'({tx_out, tx_busy, bit_cnt_out}), 32'(6'b100000));
        starts_q.delete();
        tick(80);
        chk("rst_no_frames", 32'(starts_q.size()), 32'(0));

        // Loopback-style recovery at baud 16.
        baud = 20'd16;
        starts_q.delete();
        send_byte(8'h55, a0);
        send_byte(8'hAA, a0);
        send_byte(8'h00, a0);
        send_byte(8'hFF, a0);
        wait_idle(1000);
        chk("loop_nframes", 32'(starts_q.size()), 32'(4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
